// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter for two valid/ready sources feeding a
// 2:1 data mux, with a 1-entry registered output stage and saturating
// per-source transfer counters. sel=1 selects source A.
module rr_mux_arbiter #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              sel,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  cnt_a,
   output logic [CNT_W-1:0]  cnt_b
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   // pri=1 favours A in the next contest, pri=0 favours B
   logic pri;

   logic loadEn;
   logic grantA;
   logic xferA;
   logic xferB;
   logic xfer;

   // Grant and handshake: contested grants follow pri; an idle cycle holds pri on sel
   always_comb begin
      loadEn = !out_valid | out_ready;
      grantA = pri;
      if (a_valid && !b_valid) begin
         grantA = 1'b1;
      end else if (!a_valid && b_valid) begin
         grantA = 1'b0;
      end
      sel     = grantA;
      xferA   = loadEn & a_valid & grantA;
      xferB   = loadEn & b_valid & !grantA;
      xfer    = xferA | xferB;
      a_ready = xferA;
      b_ready = xferB;
   end

   // Output stage and priority: load the winner, or drain when the consumer takes the item
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 1'b0;
         pri       <= 1'b1;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= grantA ? a_data : b_data;
         out_src   <= grantA;
         pri       <= !grantA;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating transfer counters, one per source
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else begin
         if (xferA && (cnt_a != CntMax)) begin
            cnt_a <= cnt_a + CntOne;
         end
         if (xferB && (cnt_b != CntMax)) begin
            cnt_b <= cnt_b + CntOne;
         end
      end
   end

endmodule
